// File: rtl/ins_mem_loader_pkg.sv
// Shared CPU-side definitions for the instruction-memory loader:
// memory geometry defaults, loader FSM encoding and a count-check helper.
package ins_mem_loader_pkg;

    // Instruction memory geometry
    localparam int unsigned INS_W_DEF   = 20;
    localparam int unsigned IMEM_DEPTH  = 64;
    localparam int unsigned IMEM_ADDR_W = 6;

    // Loader FSM encoding
    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StB0,
        StB1,
        StB2,
        StWrite,
        StErr
    } loader_state_e;

    // A program must hold at least one word and must fit in the memory.
    function automatic logic count_valid(input logic [7:0] n, input int unsigned depth);
        return (n != 8'd0) && (32'(n) <= depth);
    endfunction

endpackage

// File: rtl/ins_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface ins_mem_loader_if
    import ins_mem_loader_pkg::*;
#(
    parameter int unsigned INS_W  = INS_W_DEF,
    parameter int unsigned ADDR_W = IMEM_ADDR_W
) ();

    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [INS_W-1:0]  wr_data;
    logic              cpu_stall;
    logic              done;
    logic              err;

    // Host side: issues start and the byte stream, observes everything else.
    modport master (
        output start, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_stall, done, err
    );

    // Loader side.
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_stall, done, err
    );

endinterface

// File: rtl/ins_mem_loader.sv
// Program loader: reads a word count N followed by N three-byte little-endian
// instructions from a byte stream and writes them to instruction memory from
// address 0 upward, stalling the CPU while the load is in progress.
module ins_mem_loader
    import ins_mem_loader_pkg::*;
#(
    parameter int unsigned INS_W  = INS_W_DEF,
    parameter int unsigned DEPTH  = IMEM_DEPTH,
    parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    ins_mem_loader_if.slave bus
);

    loader_state_e     state_q, state_d;
    logic [7:0]        n_q, n_d;        // words to load
    logic [7:0]        cnt_q, cnt_d;    // words written so far
    logic [7:0]        b0_q, b0_d;
    logic [7:0]        b1_q, b1_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INS_W-1:0]  data_q, data_d;
    logic              rdy_q, rdy_d;
    logic              wen_q, wen_d;
    logic              stall_q, stall_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [7:0]        hi_bits;

    assign accept  = bus.in_valid & rdy_q;
    // Bits of the third byte that do not fit in the instruction word.
    assign hi_bits = bus.in_data >> (INS_W - 16);

    // Next-state, byte assembly and registered-output decode
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle, StErr: begin
                if (bus.start) begin
                    state_d = StCount;
                    err_d   = 1'b0;
                    cnt_d   = 8'd0;
                    addr_d  = '0;
                end
            end
            StCount: begin
                if (accept) begin
                    n_d = bus.in_data;
                    if (count_valid(bus.in_data, DEPTH)) begin
                        state_d = StB0;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
            end
            StB0: begin
                if (accept) begin
                    b0_d    = bus.in_data;
                    state_d = StB1;
                end
            end
            StB1: begin
                if (accept) begin
                    b1_d    = bus.in_data;
                    state_d = StB2;
                end
            end
            StB2: begin
                if (accept) begin
                    data_d  = {bus.in_data[INS_W-17:0], b1_q, b0_q};
                    // Flag the bad byte but still write the truncated word.
                    if (hi_bits != 8'd0) begin
                        err_d = 1'b1;
                    end
                    state_d = StWrite;
                end
            end
            StWrite: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_d < n_q) begin
                    // Only advance when another word follows, so the address
                    // never wraps past DEPTH-1.
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = StB0;
                end else begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        rdy_d   = (state_d inside {StCount, StB0, StB1, StB2});
        stall_d = !(state_d inside {StIdle, StErr});
        wen_d   = (state_d == StWrite);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            n_q     <= 8'd0;
            cnt_q   <= 8'd0;
            b0_q    <= 8'd0;
            b1_q    <= 8'd0;
            addr_q  <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            wen_q   <= 1'b0;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            wen_q   <= wen_d;
            stall_q <= stall_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.wr_en     = wen_q;
    assign bus.wr_addr   = addr_q;
    assign bus.wr_data   = data_q;
    assign bus.cpu_stall = stall_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Scoreboard bench for ins_mem_loader: the driver computes the expected
// memory writes from each byte list and queues them; a monitor compares every
// wr_en cycle and the done pulse against the queue.
`timescale 1ns/1ps
module tb_ins_mem_loader;

    localparam int unsigned INS_W  = 20;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 6;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [INS_W-1:0]  data;
        bit                last;
    } wr_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   done_count;
    int   exp_loads;
    wr_t  exp_q[$];
    logic [INS_W-1:0] mem [DEPTH];

    ins_mem_loader_if #(.INS_W(INS_W), .ADDR_W(ADDR_W)) bus ();

    ins_mem_loader #(
        .INS_W (INS_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_wr_en"}, bus.wr_en, 0);
        chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
        chk({tag, "_wr_data"}, 32'(bus.wr_data), 0);
        chk({tag, "_cpu_stall"}, bus.cpu_stall, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
    endtask

    // Monitor: every write must match the head of the scoreboard, last writes
    // must be followed by exactly one done cycle.
    initial begin
        bit  exp_done;
        bit  prev_wen;
        wr_t e;
        exp_done   = 1'b0;
        prev_wen   = 1'b0;
        done_count = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_done = 1'b0;
                prev_wen = 1'b0;
            end else begin
                chk("done_pulse", bus.done, exp_done);
                if (bus.done) done_count++;
                exp_done = 1'b0;
                if (bus.wr_en) begin
                    chk("wr_en_one_cycle", prev_wen, 0);
                    chk("in_ready_low_in_write", bus.in_ready, 0);
                    chk("write_expected", 32'(exp_q.size() != 0), 1);
                    mem[bus.wr_addr] = bus.wr_data;
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                        chk("wr_data", 32'(bus.wr_data), 32'(e.data));
                        exp_done = e.last;
                    end
                end
                prev_wen = bus.wr_en;
            end
        end
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int unsigned g;
        int guard;
        g = gaps ? $urandom_range(0, 3) : 0;
        for (int i = 0; i < int'(g); i++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("handshake_timeout", 32'(guard < 20), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Reference model: first byte is N; each following triple is one word,
    // low byte first, only the low nibble of the third byte is kept.
    task automatic run_load(input bq_t bytes, input bit gaps);
        int n;
        int nsend;
        int guard;
        bit exp_err;
        logic [7:0] b2;
        wr_t w;
        n       = int'(bytes[0]);
        exp_err = 1'b0;
        if (n == 0 || n > int'(DEPTH)) begin
            exp_err = 1'b1;
            nsend   = 1;
        end else begin
            nsend = 1 + 3 * n;
            for (int i = 0; i < n; i++) begin
                b2     = bytes[3*i+3];
                w.addr = ADDR_W'(i);
                w.data = {b2[3:0], bytes[3*i+2], bytes[3*i+1]};
                w.last = (i == n - 1);
                if (b2[7:4] != 4'h0) exp_err = 1'b1;
                exp_q.push_back(w);
            end
            exp_loads++;
        end
        pulse_start();
        chk("err_cleared_by_start", bus.err, 0);
        chk("stall_after_start", bus.cpu_stall, 1);
        for (int i = 0; i < nsend; i++) send_byte(bytes[i], gaps);
        guard = 0;
        while (bus.cpu_stall && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("load_end_stall", bus.cpu_stall, 0);
        chk("load_err", bus.err, 32'(exp_err));
        chk("load_end_in_ready", bus.in_ready, 0);
        chk("writes_drained", exp_q.size(), 0);
    endtask

    function automatic bq_t rand_load(input int n, input bit allow_hi);
        bq_t q;
        logic [7:0] b;
        q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            q.push_back(8'($urandom));
            q.push_back(8'($urandom));
            b = 8'($urandom);
            if (!(allow_hi && $urandom_range(0, 3) == 0)) b[7:4] = 4'h0;
            q.push_back(b);
        end
        return q;
    endfunction

    initial begin
        bq_t q;
        bq_t fq;
        wr_t w;
        n_checks     = 0;
        n_fail       = 0;
        exp_loads    = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("after_release");

        // Normal two-word load
        q = '{8'h02, 8'h34, 8'h12, 8'h05, 8'hCD, 8'hAB, 8'h0F};
        run_load(q, 1'b0);
        chk("normal_mem0", 32'(mem[0]), 32'h51234);
        chk("normal_mem1", 32'(mem[1]), 32'hFABCD);

        // Zero count and over-depth count, then recovery
        q = '{8'h00};
        run_load(q, 1'b0);
        q = '{8'h41};
        run_load(q, 1'b0);
        q = '{8'h01, 8'h78, 8'h56, 8'h04};
        run_load(q, 1'b0);
        chk("recover_mem0", 32'(mem[0]), 32'h45678);

        // Same normal load with random gaps
        q = '{8'h02, 8'h34, 8'h12, 8'h05, 8'hCD, 8'hAB, 8'h0F};
        run_load(q, 1'b1);

        // Random short loads, some with bad upper nibbles
        for (int k = 0; k < 5; k++) begin
            q = rand_load(int'($urandom_range(1, 8)), 1'b1);
            run_load(q, 1'b1);
        end

        // Full depth
        fq = rand_load(int'(DEPTH), 1'b0);
        run_load(fq, 1'b1);

        // Reset after B1 of the second word: first word stays, second never written
        w.addr = '0;
        w.data = 20'h32211;
        w.last = 1'b0;
        exp_q.push_back(w);
        pulse_start();
        q = '{8'h03, 8'h11, 8'h22, 8'h03, 8'h44, 8'h55};
        for (int i = 0; i < 6; i++) send_byte(q[i], 1'b0);
        rst_n = 1'b0;
        #1;
        check_zero("mid_load_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_zero("post_reset_idle");
        chk("reset_kept_mem0", 32'(mem[0]), 32'h32211);
        q = '{fq[6], fq[5], fq[4]};
        chk("reset_no_partial_mem1", 32'(mem[1]), 32'({q[0][3:0], q[1], q[2]}));

        repeat (3) @(posedge clk);
        #1;
        chk("final_writes_drained", exp_q.size(), 0);
        chk("done_count", 32'(done_count), 32'(exp_loads));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
